// File: rtl/div_pkg.sv
// Shared constants and types for the iterative divider: state encoding, op indices, alu_op bit positions.
// No logic of its own; imported by the interface, the step datapath and the controller.
package div_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_t;

  // One-hot positions inside div_op, same order as alu_op[21:18]
  localparam int DIV_OP_DIV_W  = 0;
  localparam int DIV_OP_DIV_WU = 1;
  localparam int DIV_OP_MOD_W  = 2;
  localparam int DIV_OP_MOD_WU = 3;

  localparam int ALU_OP_DIV_W  = 18;
  localparam int ALU_OP_DIV_WU = 19;
  localparam int ALU_OP_MOD_W  = 20;
  localparam int ALU_OP_MOD_WU = 21;

  typedef struct packed {
    logic is_signed;
    logic want_rem;
    logic sign_q;
    logic sign_r;
    logic div0;
  } div_info_t;

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Request/result handshake bundle between EX and the divide controller.
// Request side is valid/ready, result side is valid/ready, flush cancels, busy stalls EX.
interface div_ctrl_if;
  import div_pkg::*;

  logic            div_valid;
  logic            div_ready;
  logic [3:0]      div_op;
  logic [XLEN-1:0] div_src1;
  logic [XLEN-1:0] div_src2;
  logic            flush;
  logic            res_valid;
  logic            res_ready;
  logic [XLEN-1:0] div_result;
  logic            busy;

  modport master (
    output div_valid, div_op, div_src1, div_src2, flush, res_ready,
    input  div_ready, res_valid, div_result, busy
  );

  modport slave (
    input  div_valid, div_op, div_src1, div_src2, flush, res_ready,
    output div_ready, res_valid, div_result, busy
  );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring iteration on {rem, quo} against an unsigned divisor.
// Purely combinational, no backpressure; the controller registers the result each cycle.
module div_step
  import div_pkg::*;
(
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_nxt,
  output logic [XLEN-1:0] quo_nxt
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] trial;
  logic          no_sub;

  always_comb begin
    rem_sh  = {rem[XLEN-1:0], quo[XLEN-1]};
    trial   = rem_sh - {1'b0, divisor};
    // A bit shifted out of rem means the partial remainder already exceeds any divisor
    no_sub  = trial[XLEN] & ~rem[XLEN];
    rem_nxt = no_sub ? rem_sh : trial;
    quo_nxt = {quo[XLEN-2:0], ~no_sub};
  end

endmodule

// File: rtl/div_ctrl.sv
// Iterative 32-bit signed/unsigned divide/modulo controller for EX; busy stalls the pipe while in flight.
// Result valid 34 edges after accept; result held in DONE until res_ready, flush or reset cancels.
module div_ctrl
  import div_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  div_ctrl_if.slave dif
);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN:0]    rem;
  logic [XLEN-1:0]  quo;
  logic [XLEN-1:0]  divisor;
  logic [XLEN-1:0]  result;
  div_info_t        info;

  logic [XLEN:0]    rem_nxt;
  logic [XLEN-1:0]  quo_nxt;
  logic             op_signed;
  logic             s1;
  logic             s2;
  logic [XLEN-1:0]  quo_fix;
  logic [XLEN-1:0]  rem_fix;

  div_step u_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (divisor),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  assign op_signed = dif.div_op[DIV_OP_DIV_W] | dif.div_op[DIV_OP_MOD_W];
  assign s1        = op_signed & dif.div_src1[XLEN-1];
  assign s2        = op_signed & dif.div_src2[XLEN-1];

  // Divide by zero leaves an all-ones quotient that must not be sign-corrected
  assign quo_fix = info.div0 ? '1 : mag(quo, info.is_signed & info.sign_q);
  assign rem_fix = mag(rem[XLEN-1:0], info.is_signed & info.sign_r);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= DIV_IDLE;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      result  <= '0;
      info    <= '0;
    end else if (dif.flush) begin
      state <= DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (dif.div_valid) begin
            info.is_signed <= op_signed;
            info.want_rem  <= dif.div_op[DIV_OP_MOD_W] | dif.div_op[DIV_OP_MOD_WU];
            info.sign_q    <= s1 ^ s2;
            info.sign_r    <= s1;
            info.div0      <= (dif.div_src2 == '0);
            rem            <= '0;
            quo            <= mag(dif.div_src1, s1);
            divisor        <= mag(dif.div_src2, s2);
            cnt            <= '0;
            state          <= DIV_CALC;
          end
        end
        DIV_CALC: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(XLEN - 1)) state <= DIV_FIX;
        end
        DIV_FIX: begin
          result <= info.want_rem ? rem_fix : quo_fix;
          state  <= DIV_DONE;
        end
        DIV_DONE: begin
          if (dif.res_ready) state <= DIV_IDLE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

  assign dif.div_ready  = (state == DIV_IDLE);
  assign dif.busy       = (state != DIV_IDLE);
  assign dif.res_valid  = (state == DIV_DONE);
  assign dif.div_result = result;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: expected results are queued at accept and popped by an output monitor.
// Also covers latency, backpressure hold, flush/reset cancel and flush-vs-request collision in IDLE.
module tb_div_ctrl;
  import div_pkg::*;

  localparam logic [3:0] OP_DIV_W  = 4'b0001;
  localparam logic [3:0] OP_DIV_WU = 4'b0010;
  localparam logic [3:0] OP_MOD_W  = 4'b0100;
  localparam logic [3:0] OP_MOD_WU = 4'b1000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  div_ctrl_if dif ();

  div_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .dif (dif)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Output monitor: every result handshake must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst && dif.res_valid && dif.res_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_result: got %h, expected no result", dif.div_result);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (dif.div_result !== e) begin
          n_err++;
          $display("FAIL result: got %h, expected %h", dif.div_result, e);
        end
      end
    end
  end

  // Issue one request from IDLE and wait for res_valid; latency counts the accept edge itself
  task automatic send(input string name, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
    int lat;
    check({name, " ready"}, 32'(dif.div_ready), 32'd1);
    dif.div_valid = 1'b1;
    dif.div_op    = op;
    dif.div_src1  = a;
    dif.div_src2  = b;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    dif.div_valid = 1'b0;
    dif.div_op    = OP_MOD_W;
    dif.div_src1  = $urandom;
    dif.div_src2  = $urandom;
    lat = 1;
    while (!dif.res_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'd34);
  endtask

  task automatic drain(input string name);
    @(posedge clk); #1;
    check({name, " idle ready"}, 32'(dif.div_ready), 32'd1);
    check({name, " valid drop"}, 32'(dif.res_valid), 32'd0);
  endtask

  task automatic run(input string name, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    send(name, op, a, b, exp);
    drain(name);
  endtask

  task automatic start_cancelled(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    dif.div_valid = 1'b1;
    dif.div_op    = op;
    dif.div_src1  = a;
    dif.div_src2  = b;
    @(posedge clk); #1;
    dif.div_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    dif.div_valid = 1'b0;
    dif.div_op    = 4'b0000;
    dif.div_src1  = '0;
    dif.div_src2  = '0;
    dif.flush     = 1'b0;
    dif.res_ready = 1'b1;
    rst           = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst div_ready", 32'(dif.div_ready), 32'd1);
    check("rst res_valid", 32'(dif.res_valid), 32'd0);
    check("rst div_result", dif.div_result, 32'd0);
    check("rst busy", 32'(dif.busy), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    run("div_w 100/7",      OP_DIV_W,  32'd100,        32'd7,        32'd14);
    run("mod_w 100%7",      OP_MOD_W,  32'd100,        32'd7,        32'd2);
    run("div_w 100/-7",     OP_DIV_W,  32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2);
    run("mod_w 100%-7",     OP_MOD_W,  32'd100,        32'hFFFF_FFF9, 32'd2);
    run("mod_w -7%2",       OP_MOD_W,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFF);
    run("div_w -7/2",       OP_DIV_W,  32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD);
    run("div_wu max/2",     OP_DIV_WU, 32'hFFFF_FFFF,  32'd2,        32'h7FFF_FFFF);
    run("mod_wu max%2",     OP_MOD_WU, 32'hFFFF_FFFF,  32'd2,        32'd1);
    run("div_w ovf",        OP_DIV_W,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
    run("mod_w ovf",        OP_MOD_W,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0);
    run("div_w -16/0",      OP_DIV_W,  32'hFFFF_FFF0,  32'd0,        32'hFFFF_FFFF);
    run("mod_w -16%0",      OP_MOD_W,  32'hFFFF_FFF0,  32'd0,        32'hFFFF_FFF0);
    run("div_wu 5/0",       OP_DIV_WU, 32'd5,          32'd0,        32'hFFFF_FFFF);
    run("mod_wu 5%0",       OP_MOD_WU, 32'd5,          32'd0,        32'd5);

    // Backpressure: result must hold while res_ready is low
    dif.res_ready = 1'b0;
    send("bp div_wu 100/7", OP_DIV_WU, 32'd100, 32'd7, 32'd14);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp res_valid", 32'(dif.res_valid), 32'd1);
      check("bp div_result", dif.div_result, 32'd14);
      check("bp div_ready", 32'(dif.div_ready), 32'd0);
    end
    dif.res_ready = 1'b1;
    drain("bp");

    // Flush on the 10th CALC edge
    start_cancelled(OP_DIV_W, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    dif.flush = 1'b1;
    @(posedge clk); #1;
    dif.flush = 1'b0;
    check("flush busy", 32'(dif.busy), 32'd0);
    check("flush div_ready", 32'(dif.div_ready), 32'd1);
    check("flush res_valid", 32'(dif.res_valid), 32'd0);
    run("after flush div_wu 9/3", OP_DIV_WU, 32'd9, 32'd3, 32'd3);

    // Reset during CALC clears everything, including the held result
    start_cancelled(OP_DIV_WU, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("rstcalc busy", 32'(dif.busy), 32'd0);
    check("rstcalc div_ready", 32'(dif.div_ready), 32'd1);
    check("rstcalc res_valid", 32'(dif.res_valid), 32'd0);
    check("rstcalc div_result", dif.div_result, 32'd0);
    run("after rst mod_wu 10%4", OP_MOD_WU, 32'd10, 32'd4, 32'd2);

    // Request colliding with flush in IDLE must be dropped
    dif.flush = 1'b1;
    start_cancelled(OP_DIV_WU, 32'd8, 32'd2);
    dif.flush = 1'b0;
    check("idle flush busy", 32'(dif.busy), 32'd0);
    check("idle flush div_ready", 32'(dif.div_ready), 32'd1);
    repeat (40) @(posedge clk);
    #1;
    check("idle flush no result", 32'(dif.res_valid), 32'd0);

    check("queue empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
Iterative 32-bit integer divide controller for the EX stage.
- Accepts div_w / div_wu / mod_w / mod_wu operations, i.e. the decoder's alu_op[18..21] bits, together with src1/src2.
- Sequences a radix-2 restoring-division datapath over 32 cycles, then applies sign fix-up.
- Holds the result until EX consumes it, and raises busy so the pipeline stalls while the operation is in flight.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-low reset (0 = reset)
div_valid  in  1  request valid from EX
div_ready  out  1  controller can accept a request
div_op  in  4  one-hot: [0] div_w, [1] div_wu, [2] mod_w, [3] mod_wu (same order as alu_op[21:18])
div_src1  in  32  dividend (rj)
div_src2  in  32  divisor (rk)
flush  in  1  cancel in-flight operation (branch/exception flush)
res_valid  out  1  result available
res_ready  in  1  EX consumes result
div_result  out  32  quotient or remainder per div_op
busy  out  1  state != IDLE; feeds EX stall

Behaviour:
- Reset (rst=0 at edge): state=IDLE, counter=0, all internal registers 0. Outputs: div_ready=1, res_valid=0, div_result=0, busy=0.
- States and transitions:
  - IDLE: on div_valid & div_ready & ~flush, latch the following, then go to CALC with counter=0.
    - op type (signed = op[0]|op[2]; want_rem = op[2]|op[3]).
    - |src1| and |src2| for signed ops, raw values for unsigned ops.
    - sign_q = s1^s2 and sign_r = s1.
    - div0 = (src2==0).
  - CALC: one restoring step per cycle via the div_step sub-module.
    - Shift {rem,quo} left 1.
    - Trial rem - divisor; if non-negative, take the difference and set quotient LSB to 1.
    - counter++. After the 32nd step (counter==31 at edge) go to FIX.
  - FIX: apply signed correction.
    - Quotient is negated if signed & sign_q & ~div0.
    - Remainder is negated if signed & sign_r.
    - Select per want_rem into the result register, then go to DONE.
  - DONE: res_valid=1, div_result stable. On res_ready go to IDLE (res_valid drops next cycle).
- Latency: accept edge T0; CALC edges T1..T32; FIX edge T33. res_valid=1 in the cycle after T33, i.e. 34 edges after accept. Minimum initiation interval is 35 cycles with res_ready held high.
- div_ready = (state==IDLE). There is no overlap; a new request is only taken from IDLE.
- Divide by zero: no exception.
  - Quotient = 32'hFFFF_FFFF for both signed and unsigned; the sign fix is bypassed.
  - Remainder = original dividend.
- Signed overflow 0x8000_0000 / -1: quotient 0x8000_0000, remainder 0. This falls out of the unsigned magnitude path, with no special case.
- flush=1 at any edge in any non-IDLE state: go to IDLE, res_valid=0, result discarded.
  - flush with div_valid in IDLE: request is not accepted.
  - flush in DONE with res_ready: flush wins; the result is discarded, but no state difference results.
- Reset mid-operation: identical to flush, with all registers cleared.
- res_ready low in DONE: hold indefinitely; div_result must not change.
- div_op with zero or multiple bits set while div_valid: undefined; the bench must not drive it. RTL may treat it as div_wu.
- div_src1/div_src2/div_op are sampled only at the accept edge. Later changes are ignored.
- Width rules:
  - Remainder register is 33 bits so the trial subtraction produces a sign bit.
  - Negation is two's complement, 32-bit wrap.

Decomposition:
- Shared package div_pkg:
  - State encoding constants DIV_IDLE, DIV_CALC, DIV_FIX, DIV_DONE (2-bit).
  - DIV_OP_* one-hot index constants (0..3).
  - The alu_op bit positions 18..21, so the decoder and EX use identical numbering.
- Sub-module div_step (combinational): in {rem[32:0], quo[31:0], divisor[31:0]}, out next {rem, quo}. It is a single restoring iteration and is reused by a future radix-4 variant.

Test Plan:
- div_w 100 / 7 -> div_result=14, res_valid exactly 34 edges after accept; mod_w 100 % 7 -> 2.
- mod_w 0xFFFF_FFF9 (-7) % 2 -> 0xFFFF_FFFF (-1); div_w -7 / 2 -> 0xFFFF_FFFD (-3).
- div_wu 0xFFFF_FFFF / 2 -> 0x7FFF_FFFF; mod_wu -> 1; div_w 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000, mod_w -> 0.
- Divide by zero:
  - div_w 0xFFFF_FFF0 / 0 -> 0xFFFF_FFFF.
  - mod_w -> 0xFFFF_FFF0.
  - div_wu 5 / 0 -> 0xFFFF_FFFF.
  - mod_wu -> 5.
- Flush and reset cancel:
  - flush at the 10th CALC cycle -> next cycle busy=0, div_ready=1, res_valid never asserted.
  - An immediately following div_wu 9 / 3 -> 3.
  - rst=0 during CALC behaves the same.
- Backpressure and collisions:
  - res_ready held 0 for 5 cycles in DONE -> res_valid and div_result stable, div_ready=0.
  - res_ready=1 -> IDLE next cycle.
  - div_valid with flush in IDLE -> not accepted.
